// File: rtl/seg_p2s_tx.sv
// Shifts a DATA_BITS segment frame MSB-first into the display's external shift chain.
// Latency: first bit on s_out the cycle after start is sampled; start is ignored while busy.
module seg_p2s_tx #(
    parameter int DATA_BITS = 64,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] par_data,
    output logic                 s_clk,
    output logic                 s_out,
    output logic                 s_pen,
    output logic                 s_clrn,
    output logic                 busy,
    output logic                 done
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DW-1:0]        div_cnt, div_cnt_nxt;
    logic                 s_clk_nxt, s_out_nxt, s_pen_nxt, busy_nxt, done_nxt;
    logic                 load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            s_clk   <= 1'b0;
            s_out   <= 1'b0;
            s_pen   <= 1'b0;
            s_clrn  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            div_cnt <= div_cnt_nxt;
            s_clk   <= s_clk_nxt;
            s_out   <= s_out_nxt;
            s_pen   <= s_pen_nxt;
            s_clrn  <= 1'b1;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        s_clk_nxt   = 1'b0;
        s_out_nxt   = 1'b0;
        s_pen_nxt   = s_pen;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (start) load = 1'b1;
            end
            SHIFT: begin
                busy_nxt  = 1'b1;
                s_pen_nxt = 1'b0;
                s_clk_nxt = s_clk;
                s_out_nxt = shreg[DATA_BITS-1];
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    if (!s_clk) begin
                        s_clk_nxt = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        // last high phase done: leave without advancing bit_cnt so it never wraps
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        s_pen_nxt = 1'b1;
                        s_clk_nxt = 1'b0;
                        s_out_nxt = 1'b0;
                    end else begin
                        s_clk_nxt   = 1'b0;
                        shreg_nxt   = shreg << 1;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        s_out_nxt   = shreg[DATA_BITS-2];
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            DONE: begin
                if (start) load = 1'b1;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt   = SHIFT;
            shreg_nxt   = par_data;
            bit_cnt_nxt = '0;
            div_cnt_nxt = '0;
            busy_nxt    = 1'b1;
            s_pen_nxt   = 1'b0;
            s_clk_nxt   = 1'b0;
            s_out_nxt   = par_data[DATA_BITS-1];
        end
    end
endmodule

// File: tb/tb_seg_p2s_tx.sv
// Bench for seg_p2s_tx: a model of the external 64-bit shift chain captures s_out on s_clk rises
// and is compared, with frame timing, against the frame the bench requested.
module tb_seg_p2s_tx;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sel;
    logic [63:0] par_data;
    logic        start0, start1;
    logic        s_clk0, s_out0, s_pen0, s_clrn0, busy0, done0;
    logic        s_clk1, s_out1, s_pen1, s_clrn1, busy1, done1;
    logic        o_sclk, o_sout, o_pen, o_clrn, o_busy, o_done;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign o_sclk = sel ? s_clk1  : s_clk0;
    assign o_sout = sel ? s_out1  : s_out0;
    assign o_pen  = sel ? s_pen1  : s_pen0;
    assign o_clrn = sel ? s_clrn1 : s_clrn0;
    assign o_busy = sel ? busy1   : busy0;
    assign o_done = sel ? done1   : done0;

    seg_p2s_tx #(.DATA_BITS(64), .CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .par_data(par_data),
        .s_clk(s_clk0), .s_out(s_out0), .s_pen(s_pen0), .s_clrn(s_clrn0),
        .busy(busy0), .done(done0)
    );

    seg_p2s_tx #(.DATA_BITS(64), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .par_data(par_data),
        .s_clk(s_clk1), .s_out(s_out1), .s_pen(s_pen1), .s_clrn(s_clrn1),
        .busy(busy1), .done(done1)
    );

    int          tests = 0, fails = 0;
    logic [63:0] chain;
    logic        prev_sclk, prev_sout;
    int          edges, stray, hi_run, bad_run, out_run, bad_setup;
    bit          hold_start;

    function automatic int cdiv();
        return sel ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle and advance the external-chain model.
    task automatic tick();
        @(negedge clk);
        if (!o_clrn) begin
            chain   = '0;
            hi_run  = 0;
            out_run = 0;
        end else begin
            if (o_sout == prev_sout) out_run++;
            else                     out_run = 1;
            if (o_sclk && !prev_sclk) begin
                chain = {chain[62:0], o_sout};
                edges++;
                if (!o_busy) stray++;
                if (out_run < cdiv() + 1) bad_setup++;
            end
            if (o_sclk) hi_run++;
            else begin
                if (prev_sclk && hi_run != cdiv()) bad_run++;
                hi_run = 0;
            end
        end
        prev_sclk = o_sclk;
        prev_sout = o_sout;
    endtask

    task automatic frame(input logic [63:0] d, input bit kick, input bit noise);
        int cnt;
        int e0;
        int pen_bad;
        cnt = 0;
        pen_bad = 0;
        if (kick) begin
            par_data = d;
            start    = 1'b1;
        end
        tick();
        start = hold_start;
        check("first_busy", 64'(o_busy), 64'd1);
        check("first_bit", 64'(o_sout), 64'(d[63]));
        e0 = edges;
        while (!o_done && cnt < 2000) begin
            cnt++;
            if (o_pen) pen_bad++;
            if (noise) begin
                par_data = {$urandom, $urandom};
                start    = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = hold_start;
        check("done_seen", 64'(o_done), 64'd1);
        check("frame_len", 64'(cnt), 64'(64 * 2 * cdiv()));
        check("edge_count", 64'(edges - e0), 64'd64);
        check("chain_data", chain, d);
        check("pen_done", 64'(o_pen), 64'd1);
        check("busy_done", 64'({o_busy, o_sclk, o_sout}), 64'd0);
        check("pen_shift", 64'(pen_bad), 64'd0);
        check("timing", 64'(stray + bad_run + bad_setup), 64'd0);
    endtask

    task automatic expect_idle();
        tick();
        check("idle", 64'({o_done, o_busy, o_sclk, o_pen, o_clrn}), 64'b00011);
    endtask

    initial begin
        int n;
        int e0;
        int dcnt;
        rst = 1'b1; start = 1'b1; sel = 1'b0; par_data = '0; hold_start = 1'b0;
        chain = '0; prev_sclk = 1'b0; prev_sout = 1'b0;
        edges = 0; stray = 0; hi_run = 0; bad_run = 0; out_run = 0; bad_setup = 0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outs0", 64'({s_clk0, s_out0, s_pen0, s_clrn0, busy0, done0}), 64'd0);
        end
        check("rst_outs1", 64'({s_clk1, s_out1, s_pen1, s_clrn1, busy1, done1}), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check("post_rst", 64'({o_clrn, o_pen, o_busy, o_sclk, o_done}), 64'b10000);
        check("rst_edges", 64'(edges), 64'd0);

        frame(64'h8000_0000_0000_0001, 1'b1, 1'b0);
        expect_idle();
        frame(64'hC0F9_A4B0_9992_82F8, 1'b1, 1'b0);
        expect_idle();

        // back-to-back frames with start held
        hold_start = 1'b1;
        frame({$urandom, $urandom}, 1'b1, 1'b0);
        par_data = {$urandom, $urandom};
        frame(par_data, 1'b0, 1'b0);
        par_data = {$urandom, $urandom};
        hold_start = 1'b0;
        frame(par_data, 1'b0, 1'b0);
        expect_idle();

        // start pulses and par_data churn mid-frame
        for (int i = 0; i < 3; i++) begin
            frame({$urandom, $urandom}, 1'b1, 1'b1);
            expect_idle();
        end

        // reset mid-frame
        par_data = {$urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = edges;
        n = 0;
        while (edges - e0 < 30 && n < 1000) begin
            tick();
            n++;
        end
        check("reach_bit30", 64'(edges - e0), 64'd30);
        rst = 1'b1;
        tick();
        check("abort_outs", 64'({o_sclk, o_clrn, o_busy, o_done, o_pen}), 64'd0);
        check("abort_chain", chain, 64'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_done) dcnt++;
        end
        check("abort_nodone", 64'(dcnt), 64'd0);
        check("abort_pen", 64'({o_pen, o_clrn}), 64'b01);
        frame({$urandom, $urandom}, 1'b1, 1'b0);
        expect_idle();

        // CLK_DIV = 1 instance
        sel = 1'b1;
        tick();
        frame(64'hC0F9_A4B0_9992_82F8, 1'b1, 1'b0);
        expect_idle();
        for (int i = 0; i < 3; i++) begin
            frame({$urandom, $urandom}, 1'b1, 1'b1);
            expect_idle();
        end
        hold_start = 1'b1;
        frame({$urandom, $urandom}, 1'b1, 1'b0);
        par_data = {$urandom, $urandom};
        hold_start = 1'b0;
        frame(par_data, 1'b0, 1'b0);
        expect_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_p2s_tx.md
Name: seg_p2s_tx

Overview:
Parallel-to-serial transmitter for the 8-digit seven-segment display. Takes the 64-bit segment text produced by the hex-to-segment encoder and shifts it MSB-first into the board's external serial-in shift-register chain. Generates the serial clock, data, display-enable and chain-clear signals. Sits between the segment encoder and the board pins; one frame per start request.

Parameters:
DATA_BITS, 64, frame length in bits (8 digits x 8 segment bits)
CLK_DIV, 2, clk cycles per half period of s_clk (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request to send one frame; sampled each clk
par_data  input  DATA_BITS  segment text {digit7..digit0}, bit DATA_BITS-1 sent first
s_clk  output  1  serial shift clock to the shift-register chain (rising-edge capture)
s_out  output  1  serial data to the chain
s_pen  output  1  display enable, active-high; low while shifting
s_clrn  output  1  chain clear, active-low
busy  output  1  high while a frame is being shifted
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; s_clk=0, s_out=0, s_pen=0, s_clrn=0, busy=0, done=0; shift register and counters cleared. The first edge with rst=0 sets s_clrn=1; it stays 1 until the next reset.
- s_pen stays 0 from reset until the first frame completes, so no garbage is ever displayed.
- States: IDLE, SHIFT, DONE.
- IDLE: s_clk=0, busy=0, s_pen holds its value. On start=1, latch par_data into a shift register, set bit_cnt=0 and div_cnt=0, and go to SHIFT.
- SHIFT: busy=1, s_pen=0, s_out = shreg[DATA_BITS-1].
  - Each bit occupies 2*CLK_DIV clk cycles: s_clk=0 for CLK_DIV cycles, then s_clk=1 for CLK_DIV cycles. The rising edge of s_clk falls mid-bit, with s_out stable for CLK_DIV cycles before and after it.
  - At the end of the high phase, shift shreg left by 1 and increment bit_cnt.
  - After bit DATA_BITS-1's high phase, go to DONE.
- DONE: exactly one cycle. s_clk=0, busy=0, done=1; s_pen rises to 1 on entry and holds; s_out=0. Next state is SHIFT if start=1 (new par_data latched), else IDLE.
- Latency: start sampled at edge k puts the first bit on s_out from cycle k+1.
- Frame length: DATA_BITS*2*CLK_DIV cycles in SHIFT (256 at defaults), then one DONE cycle.
- Exactly DATA_BITS rising edges of s_clk per frame; none in IDLE or DONE.
- start while in SHIFT is ignored and not queued.
- par_data changes during SHIFT have no effect; the frame uses the latched copy.
- Reset mid-SHIFT aborts immediately:
  - all outputs go to their reset values, including s_clrn=0, which clears the external chain;
  - no done pulse is issued;
  - s_pen=0 until a later frame completes.
- Counters: bit_cnt is clog2(DATA_BITS) wide; div_cnt is clog2(CLK_DIV) wide, minimum 1 bit. Counters never wrap inside a frame. bit_cnt compares against DATA_BITS-1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Hold rst for 3 cycles with start=1 -> during reset all outputs are 0 (s_clrn=0); the cycle after release s_clrn=1, s_pen=0, busy=0; no s_clk edges.
2. start pulse with par_data=64'h8000_0000_0000_0001, CLK_DIV=2:
   - busy high 256 cycles; 64 s_clk rising edges;
   - value captured at edge 1 is 1, edges 2-63 capture 0, edge 64 captures 1;
   - done pulses once at cycle 257; s_pen=1 afterwards.
3. Bench model of a 64-bit shift register with par_data=64'hC0F9_A4B0_9992_82F8 -> after done, the model contents equal 64'hC0F9_A4B0_9992_82F8 exactly.
4. Start behaviour:
   - start held high continuously -> back-to-back frames; each DONE is a single cycle followed immediately by SHIFT; s_pen drops to 0 during each SHIFT.
   - Extra start pulses mid-frame -> frame length unchanged at 256 cycles.
5. rst asserted at bit 30 of a frame -> the next cycle s_clk=0, s_clrn=0, busy=0, done never pulses; a new start after release sends a full 64-bit frame.
6. CLK_DIV=1 -> s_clk toggles every clk; frame=128 cycles; 64 rising edges; data captured correctly by the bench model.
